// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions: fetch-sequencer state encoding and
// architectural constants used by the IF stage.
package rv32_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    function automatic logic word_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// IF-stage PC and fetch sequencer: drives the instruction-memory handshake,
// follows EX-stage redirects and feeds the IF/ID register.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = rv32_pkg::DEFAULT_RESET_VECTOR,
    parameter logic [31:0] NOP_INSTR    = rv32_pkg::NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        STALL,
    input  logic        BRANCH_SELECT,
    input  logic [31:0] TARGET_ADDRESS,
    input  logic        FLUSH_REQ,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_PC_PLUS_4,
    output logic [31:0] INSTRUCTION,
    output logic        INSTR_VALID,
    output logic        FLUSH_IFID,
    output logic        FLUSH_IDEX,
    output logic        MISALIGNED
);
    import rv32_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_addr_q, fetch_addr_d;
    logic [31:0]  pending_pc_q, pending_pc_d;
    logic [31:0]  ifid_pc_q, ifid_pc_d;
    logic [31:0]  ifid_pc_plus_4_q, ifid_pc_plus_4_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic         misaligned_q, misaligned_d;
    logic         imem_read_q, imem_read_d;
    logic         taken_s;
    logic         bad_target_s;

    assign taken_s      = BRANCH_SELECT & FLUSH_REQ;
    assign bad_target_s = taken_s & word_misaligned(TARGET_ADDRESS);

    // Next-state and next-output computation for the fetch sequencer.
    always_comb begin
        state_d          = state_q;
        fetch_addr_d     = fetch_addr_q;
        pending_pc_d     = pending_pc_q;
        ifid_pc_d        = ifid_pc_q;
        ifid_pc_plus_4_d = ifid_pc_plus_4_q;
        instr_d          = instr_q;
        valid_d          = valid_q;
        misaligned_d     = misaligned_q;

        if (bad_target_s && (state_q != S_HALT)) begin
            state_d      = S_HALT;
            misaligned_d = 1'b1;
            valid_d      = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH;
                    if (taken_s) begin
                        fetch_addr_d = TARGET_ADDRESS;
                    end else begin
                        fetch_addr_d = fetch_addr_q;
                    end
                end
                S_FETCH: begin
                    if (taken_s) begin
                        valid_d = 1'b0;
                        if (IMEM_BUSYWAIT) begin
                            // Outstanding read must finish at the old address first.
                            pending_pc_d = TARGET_ADDRESS;
                            state_d      = S_DRAIN;
                        end else begin
                            fetch_addr_d = TARGET_ADDRESS;
                        end
                    end else if (STALL) begin
                        valid_d = valid_q;
                    end else if (!IMEM_BUSYWAIT) begin
                        instr_d          = IMEM_READDATA;
                        valid_d          = 1'b1;
                        ifid_pc_d        = fetch_addr_q;
                        ifid_pc_plus_4_d = fetch_addr_q + 32'd4;
                        fetch_addr_d     = fetch_addr_q + 32'd4;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                S_DRAIN: begin
                    valid_d = 1'b0;
                    if (!IMEM_BUSYWAIT) begin
                        fetch_addr_d = taken_s ? TARGET_ADDRESS : pending_pc_q;
                        state_d      = S_FETCH;
                    end else if (taken_s) begin
                        pending_pc_d = TARGET_ADDRESS;
                    end else begin
                        pending_pc_d = pending_pc_q;
                    end
                end
                S_HALT: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = S_HALT;
                    valid_d = 1'b0;
                end
            endcase
        end

        instr_d     = valid_d ? instr_d : NOP_INSTR;
        imem_read_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
    end

    // Sequencer state and registered IF/ID outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q          <= S_IDLE;
            fetch_addr_q     <= RESET_VECTOR;
            pending_pc_q     <= RESET_VECTOR;
            ifid_pc_q        <= RESET_VECTOR;
            ifid_pc_plus_4_q <= RESET_VECTOR + 32'd4;
            instr_q          <= NOP_INSTR;
            valid_q          <= 1'b0;
            misaligned_q     <= 1'b0;
            imem_read_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            fetch_addr_q     <= fetch_addr_d;
            pending_pc_q     <= pending_pc_d;
            ifid_pc_q        <= ifid_pc_d;
            ifid_pc_plus_4_q <= ifid_pc_plus_4_d;
            instr_q          <= instr_d;
            valid_q          <= valid_d;
            misaligned_q     <= misaligned_d;
            imem_read_q      <= imem_read_d;
        end
    end

    assign IMEM_READ      = imem_read_q;
    assign IMEM_ADDRESS   = fetch_addr_q;
    assign IFID_PC        = ifid_pc_q;
    assign IFID_PC_PLUS_4 = ifid_pc_plus_4_q;
    assign INSTRUCTION    = instr_q;
    assign INSTR_VALID    = valid_q;
    assign MISALIGNED     = misaligned_q;
    // Redirect flushes are combinational so the younger stages die in the same cycle.
    assign FLUSH_IFID     = taken_s & (state_q != S_HALT);
    assign FLUSH_IDEX     = taken_s & (state_q != S_HALT);

endmodule
